// File: rtl/queue_rr_arbiter_pkg.sv
// rtl/queue_rr_arbiter_pkg.sv - shared state encodings, widths and helpers for queue_rr_arbiter
package queue_rr_arbiter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  localparam int HOLD_W = 4;

  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/queue_rr_arbiter_if.sv
// rtl/queue_rr_arbiter_if.sv - dequeue, release and queue-side signal bundle for queue_rr_arbiter
interface queue_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int NUM_REL = 2,
  parameter int WIDTH   = 6
);
  import queue_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         gnt_data;
  logic [NUM_REL-1:0]       rel_valid;
  logic [NUM_REL*WIDTH-1:0] rel_data;
  logic                     rel_ready;
  logic                     q_deque;
  logic [WIDTH-1:0]         q_deque_data;
  logic                     q_empty;
  logic                     q_enque;
  logic [WIDTH-1:0]         q_enque_data;
  logic                     q_full;

  // Arbiter side
  modport master (
    input  req, rel_valid, rel_data, q_deque_data, q_empty, q_full,
    output gnt, gnt_data, rel_ready, q_deque, q_enque, q_enque_data
  );

  // Requesters, release sources and queue side
  modport slave (
    output req, rel_valid, rel_data, q_deque_data, q_empty, q_full,
    input  gnt, gnt_data, rel_ready, q_deque, q_enque, q_enque_data
  );

endinterface

// File: rtl/queue_rr_arbiter_rr_picker.sv
// rtl/queue_rr_arbiter_rr_picker.sv - combinational round-robin one-hot select starting at ptr
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan ptr, ptr+1, ... modulo N and take the first active request
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/queue_rr_arbiter.sv
// rtl/queue_rr_arbiter.sv - round-robin dequeue arbiter plus release merge buffer; QUEUE_ARB_STARVE_EN enables starve_cnt
module queue_rr_arbiter
  import queue_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_REL    = 2,
  parameter int WIDTH      = 6,
  parameter int REL_DEPTH  = 4,
  parameter int FLUSH_HOLD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  queue_rr_arbiter_if.master  bus,
  output logic [7:0]          starve_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = (REL_DEPTH > 1) ? $clog2(REL_DEPTH) : 1;
  localparam int CW = $clog2(REL_DEPTH + 1);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned n);
    int unsigned s;
    s = 32'(a) + n;
    s = s % 32'(REL_DEPTH);
    return s[IW-1:0];
  endfunction

  arb_state_e        state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [PW-1:0]     rr_ptr, rr_nx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              grant_en;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Zero-latency grant path; reset kills any pending grant immediately
  always_comb begin
    grant_en     = reset && (state == RUN) && !flush && !stall && !bus.q_empty && pick_any;
    bus.q_deque  = grant_en;
    bus.gnt      = grant_en ? pick_onehot : '0;
    bus.gnt_data = grant_en ? bus.q_deque_data : '0;
  end

  // Next state: hold_cnt counts the suppressed cycles left after flush drops
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    rr_nx    = rr_ptr;
    if (flush) begin
      hold_nx  = HOLD_W'(FLUSH_HOLD);
      rr_nx    = '0;
      state_nx = (FLUSH_HOLD == 0) ? RUN : HOLD;
    end else if (state == HOLD) begin
      if (hold_cnt <= HOLD_W'(1)) begin
        hold_nx  = '0;
        state_nx = RUN;
      end else begin
        hold_nx = hold_cnt - HOLD_W'(1);
      end
    end else if (grant_en) begin
      rr_nx = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
    end
  end

  // FSM, hold counter and round-robin pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      rr_ptr   <= rr_nx;
    end
  end

  logic [WIDTH-1:0] rel_buf [REL_DEPTH];
  logic [IW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [IW-1:0]    wr_idx [NUM_REL];
  int unsigned      n_acc;
  logic             drain;

  // Acceptance, per-source slot placement and drain decision from registered count
  always_comb begin
    int unsigned off;
    off           = 0;
    bus.rel_ready = (32'(count) <= 32'(REL_DEPTH - NUM_REL));
    n_acc         = bus.rel_ready ? count_ones(32'(bus.rel_valid)) : 0;
    drain         = (count != '0) && !bus.q_full;
    for (int i = 0; i < NUM_REL; i++) begin
      wr_idx[i] = wrap_add(tail, off);
      if (bus.rel_valid[i]) off = off + 1;
    end
    bus.q_enque      = drain;
    bus.q_enque_data = drain ? rel_buf[head] : '0;
  end

  // Buffer storage; contents are meaningless while count says empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REL; i++) begin
      if (bus.rel_ready && bus.rel_valid[i]) rel_buf[wr_idx[i]] <= bus.rel_data[i*WIDTH +: WIDTH];
    end
  end

  // Buffer pointers and occupancy; stall and flush never touch these
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= wrap_add(tail, n_acc);
      head  <= drain ? wrap_add(head, 1) : head;
      count <= CW'(32'(count) + n_acc - (drain ? 32'd1 : 32'd0));
    end
  end

`ifdef QUEUE_ARB_STARVE_EN
  // Count consecutive cycles where an eligible request is refused only by an empty queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 8'd0;
    end else if (flush || grant_en) begin
      starve_cnt <= 8'd0;
    end else if ((state == RUN) && !stall && (|bus.req) && bus.q_empty && (starve_cnt != 8'hff)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve_cnt = 8'd0;
`endif

endmodule

// File: doc/queue_rr_arbiter.md
Name: queue_rr_arbiter

Overview:
- Shares one QUEUE-style FIFO between NUM_REQ consumers on the dequeue side, e.g. rename slots pulling physical tags from the free list.
- Merges NUM_REL producers on the enqueue side, e.g. commit slots returning tags, through a small release buffer.
- Sits between rename/commit and the queue instance.
- Owns round-robin fairness, one-enqueue-per-cycle serialisation and post-flush grant hold-off.

Parameters:
- NUM_REQ, 2, number of dequeue requesters.
- NUM_REL, 2, number of release (enqueue) sources.
- WIDTH, 6, data/tag width.
- REL_DEPTH, 4, release buffer entries; must be >= NUM_REL.
- FLUSH_HOLD, 1, cycles grants stay suppressed after flush deasserts (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall; blocks grants only.
- flush  in  1  pipeline flush.
- req  in  NUM_REQ  per-requester dequeue request.
- gnt  out  NUM_REQ  one-hot grant, combinational.
- gnt_data  out  WIDTH  data for granted requester; 0 when no grant.
- rel_valid  in  NUM_REL  release valid per source.
- rel_data  in  NUM_REL*WIDTH  release data; source i in bits [i*WIDTH +: WIDTH].
- rel_ready  out  1  buffer can absorb NUM_REL entries this cycle.
- q_deque  out  1  dequeue strobe to queue.
- q_deque_data  in  WIDTH  queue head data, valid same cycle as q_deque.
- q_empty  in  1  queue has no entries.
- q_enque  out  1  enqueue strobe to queue.
- q_enque_data  out  WIDTH  enqueue data.
- q_full  in  1  queue full.
- starve_cnt  out  8  consecutive cycles of requests denied by q_empty.

Behaviour:
- Reset (reset=0, async):
  - state=RUN, rr_ptr=0, hold_cnt=0.
  - Release buffer head/tail/count=0; starve_cnt=0.
  - gnt=0, q_deque=0, q_enque=0, gnt_data=0, q_enque_data=0, rel_ready=1.
- FSM states: RUN, HOLD.
  - RUN -> HOLD when flush=1. hold_cnt<=FLUSH_HOLD, rr_ptr<=0.
  - HOLD: hold_cnt decrements each cycle flush=0. Flush re-asserted in HOLD reloads hold_cnt.
  - HOLD -> RUN when hold_cnt==0 and flush=0.
  - FLUSH_HOLD=0: HOLD lasts only the flush cycles.
- Grant condition: state==RUN && !flush && !stall && !q_empty && |req.
  - Winner is the first requester with req=1 scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - When granting: q_deque=1, gnt[winner]=1, gnt_data=q_deque_data, all combinational, zero latency.
  - rr_ptr <= winner+1, wrapping to 0 after NUM_REQ-1.
  - No grant: rr_ptr holds, gnt=0, gnt_data=0. Requesters hold req until granted.
  - At most one grant per cycle.
- Release buffer: circular, REL_DEPTH entries.
  - rel_ready = (count <= REL_DEPTH-NUM_REL), computed from the registered count.
  - Sources may assert rel_valid only when rel_ready=1. If rel_valid is asserted with rel_ready=0 the inputs are dropped; this is a protocol error.
  - On an accepted cycle, valid entries are written in ascending source index order at tail. tail advances by popcount(rel_valid) with wrap.
- Drain:
  - When count>0 (registered) and !q_full: q_enque=1, q_enque_data=buf[head], head advances with wrap.
  - Fill and drain in the same cycle: count <= count + accepted - drained.
  - No bypass: a release reaches the queue no earlier than 1 cycle after acceptance.
  - stall and flush never block or clear the buffer or the drain; returned tags must not be lost.
- Reset mid-operation discards buffered releases and any pending grant immediately.

Optional Feature:
- Macro: QUEUE_ARB_STARVE_EN.
- Defined:
  - starve_cnt increments, saturating at 255, each cycle with |req && !q_empty==0 && state==RUN && !stall.
  - Clears to 0 on any grant, on flush, and on reset.
- Undefined: starve_cnt tied to 0 and no counter flops are built.

Decomposition:
- Shared package/include holds the state encodings RUN=1'b0 and HOLD=1'b1, plus the hold_cnt width of 4.
- One sub-module, rr_picker: combinational round-robin priority select of a one-hot winner from req and rr_ptr. It is reusable by other arbiters.
- Release buffer stays inline.

Test Plan:
- Reset, queue non-empty at head=0x20, req=2'b11 for 4 cycles -> gnt sequence 01,10,01,10; gnt_data tracks q_deque_data; 4 q_deque pulses.
- q_empty=1, req=2'b01 for 3 cycles -> gnt=0, gnt_data=0; starve_cnt=3 with macro, 0 without. q_empty=0 -> grant next cycle; starve_cnt clears to 0.
- stall=1 with req=2'b11 -> no q_deque and rr_ptr unchanged. stall=0 -> requester at rr_ptr is granted first.
- rel_valid=2'b11 with data 0x05/0x09, q_full=0 -> q_enque 0x05 next cycle, then 0x09; rel_ready stays 1.
- q_full=1, two release bursts fill the buffer (count=4) -> rel_ready=0. q_full=0 -> 4 enqueues in FIFO order across wrap.
- flush pulse 1 cycle with FLUSH_HOLD=1, req=2'b10 -> no grant in flush cycle and next cycle; grant to requester 0 if req=2'b11 (rr_ptr=0) on the following cycle; buffered releases still drain.
